// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: in-order 3-producer regfile write arbiter with overflow FIFO; perf counters under REGFILE_WR_ARBITER_PERF_EN
module regfile_wr_arbiter #(
    parameter int DEPTH = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_wen,
    input  logic [4:0]    a_wreg,
    input  logic [31:0]   a_wdata,
    input  logic          b_wen,
    input  logic [4:0]    b_wreg,
    input  logic [31:0]   b_wdata,
    input  logic          c_valid,
    output logic          c_ready,
    input  logic [4:0]    c_wreg,
    input  logic [31:0]   c_wdata,
    output logic          rf_wen,
    output logic [4:0]    rf_wreg,
    output logic [31:0]   rf_wdata,
    output logic          pipe_stall,
    output logic [AW:0]   occupancy,
    output logic [31:0]   perf_stall_cycles,
    output logic [AW:0]   perf_max_occ
);
    logic [4:0]    fifo_reg  [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count, count_next;
    logic          empty, pop, skip;
    logic [2:0]    src_v;
    logic [4:0]    src_r [3];
    logic [31:0]   src_d [3];
    logic [4:0]    ent_r [3];
    logic [31:0]   ent_d [3];
    logic [1:0]    n_acc, n_push;

    function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [1:0] inc);
        logic [AW:0] s;
        s = {1'b0, p} + (AW+1)'(inc);
        return s >= (AW+1)'(DEPTH) ? AW'(s - (AW+1)'(DEPTH)) : AW'(s);
    endfunction

    assign c_ready    = count < (AW+1)'(DEPTH - 3);
    assign pipe_stall = !c_ready;
    assign occupancy  = count;
    assign empty      = count == '0;
    assign src_v      = {c_valid && c_ready && c_wreg != '0, a_wen && a_wreg != '0, b_wen && b_wreg != '0};
    assign src_r      = '{b_wreg, a_wreg, c_wreg};
    assign src_d      = '{b_wdata, a_wdata, c_wdata};
    assign pop        = !empty;
    assign skip       = empty && n_acc != '0;
    assign n_push     = n_acc - {1'b0, skip};
    assign count_next = count + (AW+1)'(n_push) - (AW+1)'(pop);

    // compact accepted writes into age order: B, A, C
    always_comb begin
        n_acc = '0;
        ent_r = '{default: '0};
        ent_d = '{default: '0};
        for (int i = 0; i < 3; i++) begin
            if (src_v[i]) begin
                ent_r[n_acc] = src_r[i];
                ent_d[n_acc] = src_d[i];
                n_acc = n_acc + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (2'(j) < n_push) begin
                fifo_reg[ptr_add(tail, 2'(j))]  <= ent_r[2'(j) + {1'b0, skip}];
                fifo_data[ptr_add(tail, 2'(j))] <= ent_d[2'(j) + {1'b0, skip}];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_wen   <= 1'b0;
            rf_wreg  <= '0;
            rf_wdata <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            count  <= count_next;
            head   <= ptr_add(head, {1'b0, pop});
            tail   <= ptr_add(tail, n_push);
            rf_wen <= pop || skip;
            if (pop) begin
                rf_wreg  <= fifo_reg[head];
                rf_wdata <= fifo_data[head];
            end else if (skip) begin
                rf_wreg  <= ent_r[0];
                rf_wdata <= ent_d[0];
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && count_next > (AW+1)'(DEPTH - 1))
            $display("regfile_wr_arbiter: overflow, count would reach %0d", count_next);
    end
`endif

`ifdef REGFILE_WR_ARBITER_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_max_occ      <= '0;
        end else begin
            if (pipe_stall && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (count_next > perf_max_occ)
                perf_max_occ <= count_next;
        end
    end
`else
    assign perf_stall_cycles = '0;
    assign perf_max_occ      = '0;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed plus random stimulus checked against a pending-write queue model
module tb_regfile_wr_arbiter;
    localparam int DEPTH = 8;
    localparam int AW = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_wen, b_wen, c_valid, c_ready;
    logic [4:0]  a_wreg, b_wreg, c_wreg, rf_wreg;
    logic [31:0] a_wdata, b_wdata, c_wdata, rf_wdata, perf_stall_cycles;
    logic        rf_wen, pipe_stall;
    logic [AW:0] occupancy, perf_max_occ;

    int total = 0;
    int bad = 0;
    logic [36:0] q[$];
    logic        exp_wen;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    int          stall_cnt, max_occ;
    bit          prev_stall;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .a_wen(a_wen), .a_wreg(a_wreg), .a_wdata(a_wdata),
        .b_wen(b_wen), .b_wreg(b_wreg), .b_wdata(b_wdata),
        .c_valid(c_valid), .c_ready(c_ready), .c_wreg(c_wreg), .c_wdata(c_wdata),
        .rf_wen(rf_wen), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
        .pipe_stall(pipe_stall), .occupancy(occupancy),
        .perf_stall_cycles(perf_stall_cycles), .perf_max_occ(perf_max_occ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rf_wen", {31'b0, rf_wen}, {31'b0, exp_wen});
        chk("rf_wreg", {27'b0, rf_wreg}, {27'b0, exp_reg});
        chk("rf_wdata", rf_wdata, exp_data);
        chk("occupancy", {28'b0, occupancy}, q.size());
        chk("pipe_stall", {31'b0, pipe_stall}, {31'b0, q.size() >= DEPTH - 3});
        chk("c_ready", {31'b0, c_ready}, {31'b0, q.size() < DEPTH - 3});
`ifdef REGFILE_WR_ARBITER_PERF_EN
        chk("perf_stall", perf_stall_cycles, stall_cnt);
        chk("perf_max_occ", {28'b0, perf_max_occ}, max_occ);
`else
        chk("perf_stall", perf_stall_cycles, 32'd0);
        chk("perf_max_occ", {28'b0, perf_max_occ}, 32'd0);
`endif
    endtask

    task automatic model_reset();
        q.delete();
        exp_wen = 1'b0;
        exp_reg = '0;
        exp_data = '0;
        stall_cnt = 0;
        max_occ = 0;
        prev_stall = 1'b0;
    endtask

    // one clock: drive inputs, advance the model, check after the edge
    task automatic cycle(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bw, input logic [4:0] br, input logic [31:0] bd,
                         input logic cv, input logic [4:0] cr, input logic [31:0] cd);
        int  cnt0;
        bit  rdy;
        a_wen = aw; a_wreg = ar; a_wdata = ad;
        b_wen = bw; b_wreg = br; b_wdata = bd;
        c_valid = cv; c_wreg = cr; c_wdata = cd;
        cnt0 = q.size();
        rdy = cnt0 < DEPTH - 3;
        if (bw && br != 0) q.push_back({br, bd});
        if (aw && ar != 0) q.push_back({ar, ad});
        if (cv && rdy && cr != 0) q.push_back({cr, cd});
        if (!rdy) stall_cnt++;
        prev_stall = !rdy;
        if (q.size() != 0) begin
            {exp_reg, exp_data} = q.pop_front();
            exp_wen = 1'b1;
        end else begin
            exp_wen = 1'b0;
        end
        if (q.size() > max_occ) max_occ = q.size();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        a_wen = 0; a_wreg = 0; a_wdata = 0;
        b_wen = 0; b_wreg = 0; b_wdata = 0;
        c_valid = 0; c_wreg = 0; c_wdata = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;
        idle();

        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        chk("single_reg", {27'b0, rf_wreg}, 32'd5);
        chk("single_data", rf_wdata, 32'hDEADBEEF);
        idle();
        chk("single_done", {31'b0, rf_wen}, 32'd0);

        cycle(1, 3, 32'd2, 1, 3, 32'd1, 0, 0, 0);
        chk("coll_first", rf_wdata, 32'd1);
        idle();
        chk("coll_second", rf_wdata, 32'd2);
        idle();

        chk("three_c_ready", {31'b0, c_ready}, 32'd1);
        cycle(1, 0, 32'd9, 1, 4, 32'd7, 1, 6, 32'd8);
        chk("three_first", {27'b0, rf_wreg}, 32'd4);
        idle();
        chk("three_second", {27'b0, rf_wreg}, 32'd6);
        idle();
        chk("three_x0_gone", {31'b0, rf_wen}, 32'd0);

        for (int i = 0; i < 6; i++)
            cycle(1, 5'(i + 1), 32'(100 + i), 1, 5'(i + 10), 32'(200 + i), 0, 0, 0);
        chk("fill_stall", {31'b0, pipe_stall}, 32'd1);
        for (int i = 0; i < 8; i++) idle();

        for (int i = 0; i < 4; i++)
            cycle(1, 5'(i + 1), $urandom, 1, 5'(i + 20), $urandom, 0, 0, 0);
        chk("pre_reset_occ", {28'b0, occupancy}, 32'd4);
        a_wen = 0; b_wen = 0; c_valid = 0;
        reset = 1'b1;
        #1;
        chk("reset_rf_wen", {31'b0, rf_wen}, 32'd0);
        chk("reset_occ", {28'b0, occupancy}, 32'd0);
        model_reset();
        @(negedge clk);
        check_all();
        reset = 1'b0;
        cycle(1, 7, 32'h1234, 0, 0, 0, 0, 0, 0);
        chk("post_reset_reg", {27'b0, rf_wreg}, 32'd7);

        for (int i = 0; i < 600; i++) begin
            logic aw, bw;
            aw = !prev_stall && ($urandom_range(0, 9) < 7);
            bw = !prev_stall && ($urandom_range(0, 9) < 7);
            cycle(aw, 5'($urandom_range(0, 31)), $urandom,
                  bw, 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end
        for (int i = 0; i < 10; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
